// File: rtl/raster_to_block_if.sv
// Pixel stream bundle for the raster-to-block reorder stage.
// master = the reorder block, slave = the raster source / JPEG core side.
interface raster_to_block_if;
  logic [7:0] in_pixel;
  logic       ena_in;
  logic       rdy_out;
  logic [7:0] out_pixel;
  logic       ena_out;
  logic       rdy_in;
  logic       out_eof;

  modport master (
    input  in_pixel, ena_in, rdy_in,
    output rdy_out, out_pixel, ena_out, out_eof
  );

  modport slave (
    output in_pixel, ena_in, rdy_in,
    input  rdy_out, out_pixel, ena_out, out_eof
  );
endinterface

// File: rtl/raster_to_block.sv
// Reorders a raster greyscale stream into 8x8 block order using two ping-pong
// 8-line strip buffers and a 2-entry output FIFO.
//
// bank state     | meaning
// BANK_EMPTY     | no valid data, may start filling
// BANK_FILLING   | receiving raster pixels of a strip
// BANK_FULL      | complete strip, waiting for the read side
// BANK_DRAINING  | being read out in block order
module raster_to_block #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic              clk,
  input logic              rst,
  raster_to_block_if.master px
);

  localparam int BANK_WORDS = 8 * IMG_WIDTH;
  localparam int AW         = $clog2(BANK_WORDS);
  localparam int CW         = $clog2(IMG_WIDTH);
  localparam int NBLK       = IMG_WIDTH / 8;
  localparam int BKW        = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int NSTRIP     = IMG_HEIGHT / 8;
  localparam int SW         = (NSTRIP > 1) ? $clog2(NSTRIP) : 1;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  bank_state_t bank_st  [2];
  bank_state_t bank_nxt [2];

  logic [7:0] mem [2][BANK_WORDS];

  logic          wr_bank;
  logic [2:0]    wr_row;
  logic [CW-1:0] wr_col;
  logic [AW-1:0] wr_addr;
  logic          wr_fire;
  logic          wr_last;
  logic          rdy_out_w;

  logic           rd_bank;
  logic [BKW-1:0] rd_blk;
  logic [2:0]     rd_r;
  logic [2:0]     rd_c;
  logic [SW-1:0]  rd_strip;
  logic [AW-1:0]  rd_addr;
  logic           rd_ok;
  logic           rd_issue;
  logic           rd_last;
  logic           rd_vld;
  logic           rd_eof;
  logic [7:0]     rd_data;

  logic [7:0] f_px  [2];
  logic       f_eof [2];
  logic       f_wp;
  logic       f_rp;
  logic [1:0] f_cnt;
  logic       push;
  logic       pop;
  logic [2:0] occ;

  // Bank state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else begin
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
    end
  end

  // Bank next-state
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_nxt[b] = bank_st[b];
      case (bank_st[b])
        BANK_EMPTY: begin
          if (wr_fire && (wr_bank == 1'(b))) bank_nxt[b] = BANK_FILLING;
        end
        BANK_FILLING: begin
          if (wr_fire && (wr_bank == 1'(b)) && wr_last) bank_nxt[b] = BANK_FULL;
        end
        BANK_FULL: begin
          if (rd_bank == 1'(b)) bank_nxt[b] = BANK_DRAINING;
        end
        BANK_DRAINING: begin
          if ((rd_bank == 1'(b)) && rd_issue && rd_last) bank_nxt[b] = BANK_EMPTY;
        end
        default: bank_nxt[b] = BANK_EMPTY;
      endcase
    end
  end

  // Bank-state decode; reads may start in the same cycle the bank is seen FULL
  always_comb begin
    rdy_out_w = (bank_st[wr_bank] == BANK_EMPTY) || (bank_st[wr_bank] == BANK_FILLING);
    rd_ok     = (bank_st[rd_bank] == BANK_FULL) || (bank_st[rd_bank] == BANK_DRAINING);
  end

  always_comb begin
    wr_fire = px.ena_in & rdy_out_w;
    wr_last = (wr_row == 3'd7) && (wr_col == CW'(IMG_WIDTH - 1));
    wr_addr = AW'(wr_row) * AW'(IMG_WIDTH) + AW'(wr_col);
    rd_addr = AW'(rd_r) * AW'(IMG_WIDTH) + AW'(rd_blk) * AW'(8) + AW'(rd_c);
    rd_last = (rd_blk == BKW'(NBLK - 1)) && (rd_r == 3'd7) && (rd_c == 3'd7);
    pop     = (f_cnt != 2'd0) && px.rdy_in;
    push    = rd_vld;
    // Occupancy after this cycle's pop keeps 1 px/clk with only two entries
    occ      = 3'(f_cnt) + 3'(rd_vld) - 3'(pop);
    rd_issue = rd_ok && (occ < 3'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_row  <= 3'd0;
      wr_col  <= '0;
    end else if (wr_fire) begin
      if (wr_col == CW'(IMG_WIDTH - 1)) begin
        wr_col <= '0;
        if (wr_row == 3'd7) begin
          wr_row  <= 3'd0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_row <= wr_row + 3'd1;
        end
      end else begin
        wr_col <= wr_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_addr] <= px.in_pixel;
    if (rd_issue) rd_data <= mem[rd_bank][rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank  <= 1'b0;
      rd_blk   <= '0;
      rd_r     <= 3'd0;
      rd_c     <= 3'd0;
      rd_strip <= '0;
      rd_vld   <= 1'b0;
      rd_eof   <= 1'b0;
    end else begin
      rd_vld <= rd_issue;
      rd_eof <= rd_issue && rd_last && (rd_strip == SW'(NSTRIP - 1));
      if (rd_issue) begin
        if (rd_c == 3'd7) begin
          rd_c <= 3'd0;
          if (rd_r == 3'd7) begin
            rd_r <= 3'd0;
            if (rd_blk == BKW'(NBLK - 1)) begin
              rd_blk  <= '0;
              rd_bank <= ~rd_bank;
              if (rd_strip == SW'(NSTRIP - 1)) rd_strip <= '0;
              else rd_strip <= rd_strip + SW'(1);
            end else begin
              rd_blk <= rd_blk + BKW'(1);
            end
          end else begin
            rd_r <= rd_r + 3'd1;
          end
        end else begin
          rd_c <= rd_c + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_px[0]  <= 8'd0;
      f_px[1]  <= 8'd0;
      f_eof[0] <= 1'b0;
      f_eof[1] <= 1'b0;
      f_wp     <= 1'b0;
      f_rp     <= 1'b0;
      f_cnt    <= 2'd0;
    end else begin
      if (push) begin
        f_px[f_wp]  <= rd_data;
        f_eof[f_wp] <= rd_eof;
        f_wp        <= ~f_wp;
      end
      if (pop) f_rp <= ~f_rp;
      f_cnt <= f_cnt + 2'(push) - 2'(pop);
    end
  end

  assign px.rdy_out   = rdy_out_w;
  assign px.ena_out   = (f_cnt != 2'd0);
  assign px.out_pixel = f_px[f_rp];
  assign px.out_eof   = f_eof[f_rp];

endmodule
